// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flags stage: ARM condition encodings and NZCV bit positions.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    localparam int unsigned N_B = 3;
    localparam int unsigned Z_B = 2;
    localparam int unsigned C_B = 1;
    localparam int unsigned V_B = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: decides whether an instruction executes given stored NZCV.
module cond_check
    import cond_pkg::*;
#(
    parameter bit RESERVED_COND_EX = 1'b0
) (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic  n, z, c, v;
    cond_t cond_e;

    assign n      = Flags[N_B];
    assign z      = Flags[Z_B];
    assign c      = Flags[C_B];
    assign v      = Flags[V_B];
    assign cond_e = cond_t'(Cond);

    always_comb begin
        CondEx = 1'b0;
        unique case (cond_e)
            EQ: CondEx = z;
            NE: CondEx = ~z;
            CS: CondEx = c;
            CC: CondEx = ~c;
            MI: CondEx = n;
            PL: CondEx = ~n;
            VS: CondEx = v;
            VC: CondEx = ~v;
            HI: CondEx = c & ~z;
            LS: CondEx = ~c | z;
            GE: CondEx = (n == v);
            LT: CondEx = (n != v);
            GT: CondEx = ~z & (n == v);
            LE: CondEx = z | (n != v);
            AL: CondEx = 1'b1;
            NV: CondEx = RESERVED_COND_EX;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Condition/flags stage: holds NZCV, gates write strobes by the condition result and stall/flush,
// and registers the condition result for later multicycle use.
module cond_logic
    import cond_pkg::*;
#(
    parameter bit RESERVED_COND_EX = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       CondExReg,
    output logic [3:0] Flags,
    output logic       carry
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_reg_q, cond_ex_reg_d;
    logic       kill;
    logic       commit;

    cond_check #(
        .RESERVED_COND_EX(RESERVED_COND_EX)
    ) u_cond_check (
        .Cond  (Cond),
        .Flags (flags_q),
        .CondEx(CondEx)
    );

    assign kill   = stall | flush;
    assign commit = CondEx & ~kill;

    always_comb begin
        PCSrc    = PCS & commit;
        RegWrite = RegW & ~NoWrite & commit;
        MemWrite = MemW & commit;
    end

    // N/Z and C/V halves update independently; a failed or killed instruction leaves both alone.
    always_comb begin
        flags_d = flags_q;
        if (commit) begin
            if (FlagW[1]) begin
                flags_d[N_B] = ALUFlags[N_B];
                flags_d[Z_B] = ALUFlags[Z_B];
            end
            if (FlagW[0]) begin
                flags_d[C_B] = ALUFlags[C_B];
                flags_d[V_B] = ALUFlags[V_B];
            end
        end
    end

    always_comb begin
        cond_ex_reg_d = cond_ex_reg_q;
        if (flush) begin
            cond_ex_reg_d = 1'b0;
        end else if (!stall) begin
            cond_ex_reg_d = CondEx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q       <= 4'b0000;
            cond_ex_reg_q <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            cond_ex_reg_q <= cond_ex_reg_d;
        end
    end

    assign Flags     = flags_q;
    assign carry     = flags_q[C_B];
    assign CondExReg = cond_ex_reg_q;

endmodule
